// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel complementary PWM with dead time and double-buffered configuration
module pwm_multi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DT_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      pwm_center,
  input  logic [WIDTH-1:0]          pwm_period,
  input  logic [CHANNELS*WIDTH-1:0] pwm_compare,
  input  logic [DT_WIDTH-1:0]       pwm_deadtime,
  input  logic                      pwm_load,
  output logic                      pwm_pending,
  output logic                      pwm_fetch,
  output logic [CHANNELS-1:0]       pwm_high,
  output logic [CHANNELS-1:0]       pwm_low
);

  localparam logic [0:0]          DIR_UP   = 1'b0;
  localparam logic [0:0]          DIR_DOWN = 1'b1;
  localparam logic [WIDTH-1:0]    ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0]    ZERO     = '0;
  localparam logic [DT_WIDTH-1:0] DT_ONE   = DT_WIDTH'(1);
  localparam logic [DT_WIDTH-1:0] DT_ZERO  = '0;

  // shared period counter
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [0:0]       dir;
  logic [0:0]       dir_next;

  // live configuration and the shadow copy waiting for a period boundary
  logic                      act_center;
  logic [WIDTH-1:0]          act_period;
  logic [CHANNELS*WIDTH-1:0] act_compare;
  logic [DT_WIDTH-1:0]       act_deadtime;
  logic                      sh_center;
  logic [WIDTH-1:0]          sh_period;
  logic [CHANNELS*WIDTH-1:0] sh_compare;
  logic [DT_WIDTH-1:0]       sh_deadtime;
  logic                      pending;

  logic update;
  logic apply_cfg;

  // per-channel output state: raw comparator, last raw seen, entered flag, dead counter
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] tgt;
  logic [CHANNELS-1:0] live;
  logic [DT_WIDTH-1:0] dcnt [CHANNELS];

  // next counter value and direction; the counter never passes the active period
  always_comb begin
    count_next = ZERO;
    dir_next   = DIR_UP;
    if (!act_center) begin
      if (count < act_period) begin
        count_next = count + ONE;
      end
    end else if (dir == DIR_UP) begin
      if (count < act_period) begin
        count_next = count + ONE;
      end else if (act_period != ZERO) begin
        // turning point at P; P=1 drops straight back to 0 and stays counting up
        count_next = count - ONE;
        dir_next   = (count == ONE) ? DIR_UP : DIR_DOWN;
      end
    end else begin
      if (count > ONE) begin
        count_next = count - ONE;
        dir_next   = DIR_DOWN;
      end
    end
  end

  // period boundary: the next cycle starts at count 0; while stopped the shadow passes through
  assign update    = enable && (count_next == ZERO);
  assign apply_cfg = !enable || update;

  assign pwm_fetch   = enable && (count == ZERO);
  assign pwm_pending = pending;

  // raw pulse per channel against the active compare value
  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = count < act_compare[i*WIDTH +: WIDTH];
    end
  end

  // period counter; stopped means parked at 0 counting up
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      count <= ZERO;
      dir   <= DIR_UP;
    end else begin
      count <= count_next;
      dir   <= dir_next;
    end
  end

  // double-buffered configuration; a load on the boundary cycle goes live immediately
  always_ff @(posedge clock) begin
    if (reset) begin
      act_center   <= 1'b0;
      act_period   <= ZERO;
      act_compare  <= '0;
      act_deadtime <= DT_ZERO;
      sh_center    <= 1'b0;
      sh_period    <= ZERO;
      sh_compare   <= '0;
      sh_deadtime  <= DT_ZERO;
      pending      <= 1'b0;
    end else begin
      if (pwm_load) begin
        sh_center   <= pwm_center;
        sh_period   <= pwm_period;
        sh_compare  <= pwm_compare;
        sh_deadtime <= pwm_deadtime;
      end
      if (apply_cfg) begin
        pending <= 1'b0;
        if (pwm_load) begin
          act_center   <= pwm_center;
          act_period   <= pwm_period;
          act_compare  <= pwm_compare;
          act_deadtime <= pwm_deadtime;
        end else if (pending) begin
          act_center   <= sh_center;
          act_period   <= sh_period;
          act_compare  <= sh_compare;
          act_deadtime <= sh_deadtime;
        end
      end else if (pwm_load) begin
        pending <= 1'b1;
      end
    end
  end

  // complementary gate drive with dead time; only one side is ever driven at a time
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      pwm_high <= '0;
      pwm_low  <= '0;
      tgt      <= '0;
      live     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt[i] <= DT_ZERO;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!live[i] || (raw[i] != tgt[i])) begin
          // new target (or first entry from the safe state): blank both sides for D clocks
          live[i] <= 1'b1;
          tgt[i]  <= raw[i];
          if (act_deadtime == DT_ZERO) begin
            pwm_high[i] <= raw[i];
            pwm_low[i]  <= ~raw[i];
            dcnt[i]     <= DT_ZERO;
          end else begin
            pwm_high[i] <= 1'b0;
            pwm_low[i]  <= 1'b0;
            dcnt[i]     <= act_deadtime;
          end
        end else if (dcnt[i] > DT_ONE) begin
          dcnt[i] <= dcnt[i] - DT_ONE;
        end else begin
          dcnt[i]     <= DT_ZERO;
          pwm_high[i] <= raw[i];
          pwm_low[i]  <= ~raw[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - directed table and sequence checks for pwm_multi
module tb_pwm_multi;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_center;
  logic [31:0]  pwm_period;
  logic [127:0] pwm_compare;
  logic [7:0]   pwm_deadtime;
  logic         pwm_load;
  logic         pwm_pending;
  logic         pwm_fetch;
  logic [3:0]   pwm_high;
  logic [3:0]   pwm_low;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_multi #(.WIDTH(32), .CHANNELS(4), .DT_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pwm_center(pwm_center),
    .pwm_period(pwm_period),
    .pwm_compare(pwm_compare),
    .pwm_deadtime(pwm_deadtime),
    .pwm_load(pwm_load),
    .pwm_pending(pwm_pending),
    .pwm_fetch(pwm_fetch),
    .pwm_high(pwm_high),
    .pwm_low(pwm_low)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         en;
    logic         ld;
    logic         ctr;
    logic [31:0]  per;
    logic [127:0] cmp;
    logic [7:0]   dt;
    logic         f;
    logic         pd;
    logic [3:0]   hi;
    logic [3:0]   lo;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic ld, input logic f, input logic pd,
                              input logic [3:0] hi, input logic [3:0] lo);
    vec_t v;
    v.en  = en;
    v.ld  = ld;
    v.ctr = 1'b0;
    v.per = 32'd9;
    v.cmp = {32'd5, 32'd10, 32'd3, 32'd0};
    v.dt  = 8'd0;
    v.f   = f;
    v.pd  = pd;
    v.hi  = hi;
    v.lo  = lo;
    return v;
  endfunction

  // stopped cycle that loads a configuration directly into the active set
  task automatic stop_and_load(input logic ctr, input logic [31:0] per,
                               input logic [127:0] cmp, input logic [7:0] dt);
    @(negedge clock);
    enable = 1'b0; pwm_load = 1'b1;
    pwm_center = ctr; pwm_period = per; pwm_compare = cmp; pwm_deadtime = dt;
    @(negedge clock);
    pwm_load = 1'b0;
  endtask

  function automatic int unsigned csq(input int k);
    int unsigned s [8];
    s = '{0, 1, 2, 3, 4, 3, 2, 1};
    return s[k % 8];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        r;
    int          hcnt;
    int          fcnt;
    int          cprev;
    int          cnow;

    reset = 1'b1; enable = 1'b0; pwm_center = 1'b0; pwm_period = '0;
    pwm_compare = '0; pwm_deadtime = '0; pwm_load = 1'b0;

    // edge mode P=9, C={0,3,10,5} on ch0..ch3, D=0; low side is the exact complement
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b0011);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b0011);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1011);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1011);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1011);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1011);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b1011);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b0011);

    // reset state
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_pending", 32'(pwm_pending), 32'd0);
    chk("rst_high", 32'(pwm_high), 32'd0);
    chk("rst_low", 32'(pwm_low), 32'd0);
    chk("rst_fetch", 32'(pwm_fetch), 32'd0);

    // P=0 after reset: fetch every enabled cycle, low side enters with D=0
    @(negedge clock);
    reset = 1'b0; enable = 1'b1;
    #1;
    chk("p0_fetch_a", 32'(pwm_fetch), 32'd1);
    @(negedge clock);
    #1;
    chk("p0_fetch_b", 32'(pwm_fetch), 32'd1);
    chk("p0_low", 32'(pwm_low), 32'hf);
    @(negedge clock);
    enable = 1'b0;
    #1;
    chk("p0_fetch_off", 32'(pwm_fetch), 32'd0);

    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      enable = tbl[k].en; pwm_load = tbl[k].ld; pwm_center = tbl[k].ctr;
      pwm_period = tbl[k].per; pwm_compare = tbl[k].cmp; pwm_deadtime = tbl[k].dt;
      #1;
      chk($sformatf("t1_fetch[%0d]", k), 32'(pwm_fetch), 32'(tbl[k].f));
      chk($sformatf("t1_pending[%0d]", k), 32'(pwm_pending), 32'(tbl[k].pd));
      chk($sformatf("t1_high[%0d]", k), 32'(pwm_high), 32'(tbl[k].hi));
      chk($sformatf("t1_low[%0d]", k), 32'(pwm_low), 32'(tbl[k].lo));
    end

    // center mode P=4, C0=2: counts 0,1,2,3,4,3,2,1 per 8 cycles
    stop_and_load(1'b1, 32'd4, {96'd0, 32'd2}, 8'd0);
    hcnt = 0; fcnt = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clock);
      enable = 1'b1;
      #1;
      chk($sformatf("t2_fetch[%0d]", k), 32'(pwm_fetch), 32'(csq(k) == 0));
      if (k < 8 && pwm_fetch) fcnt++;
      if (k >= 1) begin
        r = (csq(k - 1) < 2);
        chk($sformatf("t2_high[%0d]", k), 32'(pwm_high), 32'({3'b000, r}));
        chk($sformatf("t2_low[%0d]", k), 32'(pwm_low), 32'({3'b111, ~r}));
        if (k <= 8 && pwm_high[0]) hcnt++;
      end
    end
    chk("t2_high_per_period", 32'(hcnt), 32'd3);
    chk("t2_fetch_per_period", 32'(fcnt), 32'd1);

    // dead time D=3, edge P=9, C0=5
    stop_and_load(1'b0, 32'd9, {96'd0, 32'd5}, 8'd3);
    hcnt = 0; fcnt = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) @(negedge clock);
      enable = 1'b1;
      #1;
      if (k >= 1) begin
        chk($sformatf("t3_high[%0d]", k), 32'(pwm_high),
            32'({3'b000, ((k % 10) == 4) || ((k % 10) == 5)}));
        chk($sformatf("t3_low[%0d]", k), 32'(pwm_low),
            32'({{3{k >= 4}}, ((k % 10) == 9) || ((k % 10) == 0)}));
        chk($sformatf("t3_overlap[%0d]", k), 32'(pwm_high & pwm_low), 32'd0);
        if (k >= 10 && k < 20) begin
          if (pwm_high[0]) hcnt++;
          if (pwm_low[0]) fcnt++;
        end
      end
    end
    chk("t3_high_cycles", 32'(hcnt), 32'd2);
    chk("t3_low_cycles", 32'(fcnt), 32'd2);

    // mid-period load of P=19, C0=10 while P=9, C0=5 runs
    stop_and_load(1'b0, 32'd9, {96'd0, 32'd5}, 8'd0);
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) @(negedge clock);
      enable = 1'b1;
      pwm_load = (k == 3);
      pwm_period = 32'd19; pwm_compare = {96'd0, 32'd10};
      #1;
      cnow = (k <= 9) ? k : (k - 10) % 20;
      chk($sformatf("t4_fetch[%0d]", k), 32'(pwm_fetch), 32'(cnow == 0));
      chk($sformatf("t4_pending[%0d]", k), 32'(pwm_pending), 32'((k >= 4) && (k <= 9)));
      if (k >= 1) begin
        cprev = (k - 1 <= 9) ? (k - 1) : (k - 11) % 20;
        r = (k - 1 <= 9) ? (cprev < 5) : (cprev < 10);
        chk($sformatf("t4_high[%0d]", k), 32'(pwm_high[0]), 32'(r));
      end
    end
    pwm_load = 1'b0;

    // load coincident with the boundary cycle (count==9): P=4, C0=2 from the next count 0
    stop_and_load(1'b0, 32'd9, {96'd0, 32'd5}, 8'd0);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clock);
      enable = 1'b1;
      pwm_load = (k == 9);
      pwm_period = 32'd4; pwm_compare = {96'd0, 32'd2};
      #1;
      chk($sformatf("t5_pending[%0d]", k), 32'(pwm_pending), 32'd0);
      if (k >= 10) begin
        chk($sformatf("t5_fetch[%0d]", k), 32'(pwm_fetch), 32'(((k - 10) % 5) == 0));
        r = (k == 10) ? 1'b0 : (((k - 11) % 5) < 2);
        chk($sformatf("t5_high[%0d]", k), 32'(pwm_high[0]), 32'(r));
      end
    end
    pwm_load = 1'b0;

    // enable dropped mid-pulse with D=3, re-entry through dead time, then reset with pending
    stop_and_load(1'b0, 32'd9, {96'd0, 32'd5}, 8'd3);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clock);
      enable = 1'b1;
    end
    @(negedge clock);
    enable = 1'b0;
    #1;
    chk("t6_fetch_off", 32'(pwm_fetch), 32'd0);
    chk("t6_midpulse_high", 32'(pwm_high), 32'd1);
    @(negedge clock);
    #1;
    chk("t6_off_high", 32'(pwm_high), 32'd0);
    chk("t6_off_low", 32'(pwm_low), 32'd0);
    @(negedge clock);
    enable = 1'b1;
    #1;
    chk("t6_reen_fetch", 32'(pwm_fetch), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("t6_dead_hl[%0d]", k), 32'(pwm_high | pwm_low), 32'd0);
    end
    @(negedge clock);
    #1;
    chk("t6_first_high", 32'(pwm_high), 32'h1);
    chk("t6_first_low", 32'(pwm_low), 32'he);
    @(negedge clock);
    pwm_load = 1'b1; pwm_period = 32'd19;
    @(negedge clock);
    pwm_load = 1'b0; reset = 1'b1;
    #1;
    chk("t6_pending_before_rst", 32'(pwm_pending), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_rst_pending", 32'(pwm_pending), 32'd0);
    chk("t6_rst_high", 32'(pwm_high), 32'd0);
    chk("t6_rst_low", 32'(pwm_low), 32'd0);
    chk("t6_rst_fetch", 32'(pwm_fetch), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("t6_p0_fetch[%0d]", k), 32'(pwm_fetch), 32'd1);
      chk($sformatf("t6_p0_low[%0d]", k), 32'(pwm_low), 32'hf);
      chk($sformatf("t6_p0_pending[%0d]", k), 32'(pwm_pending), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
